// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache.
// Holds the address/instruction widths, the default cache geometry, the
// FSM state type and a small helper that classifies RVC halfwords.
package icache_pkg;

    localparam int ADDR_WIDTH        = 32;
    localparam int INST_WIDTH        = 32;
    localparam int ICACHE_INDEX_BITS = 4;
    localparam int ICACHE_WORD_BITS  = 2;

    // Opcode quadant that marks a full 32-bit instruction.
    localparam logic [1:0] OPC_QUADRANT_32 = 2'b11;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } icache_state_e;

    // A halfword starts a compressed instruction unless its low bits are 11.
    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != OPC_QUADRANT_32;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Ports:
//   clk, rst_in             clock, async active-high reset (valid bits only)
//   wr_en/wr_index/wr_word  word write into the data array
//   wr_data                 word being written
//   commit_en/commit_tag    write the tag and set valid for wr_index
//   rd_index_a -> rd_valid_a, rd_tag_a, rd_line_a   full line read (line A)
//   rd_index_b -> rd_valid_b, rd_tag_b, rd_hw0_b    low halfword of word 0 (line B)
module icache_array #(
    parameter int INDEX_BITS = 4,
    parameter int WORD_BITS  = 2,
    parameter int TAG_BITS   = 24
) (
    input  logic                              clk,
    input  logic                              rst_in,
    input  logic                              wr_en,
    input  logic [INDEX_BITS-1:0]             wr_index,
    input  logic [WORD_BITS-1:0]              wr_word,
    input  logic [31:0]                       wr_data,
    input  logic                              commit_en,
    input  logic [TAG_BITS-1:0]               commit_tag,
    input  logic [INDEX_BITS-1:0]             rd_index_a,
    output logic                              rd_valid_a,
    output logic [TAG_BITS-1:0]               rd_tag_a,
    output logic [32*(1<<WORD_BITS)-1:0]      rd_line_a,
    input  logic [INDEX_BITS-1:0]             rd_index_b,
    output logic                              rd_valid_b,
    output logic [TAG_BITS-1:0]               rd_tag_b,
    output logic [15:0]                       rd_hw0_b
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << WORD_BITS;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    valid_d;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES][WORDS];

    always_comb begin
        valid_d = valid_q;
        if (commit_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_index][wr_word] <= wr_data;
        end
        if (commit_en) begin
            tag_q[wr_index] <= commit_tag;
        end
    end

    assign rd_valid_a = valid_q[rd_index_a];
    assign rd_tag_a   = tag_q[rd_index_a];
    assign rd_valid_b = valid_q[rd_index_b];
    assign rd_tag_b   = tag_q[rd_index_b];
    assign rd_hw0_b   = data_q[rd_index_b][0][15:0];

    for (genvar w = 0; w < WORDS; w++) begin : g_line_a
        assign rd_line_a[32*w +: 32] = data_q[rd_index_a][w];
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped RV32IC instruction cache.
// Returns the halfword at fetch_pc plus the following halfword for 32-bit
// instructions; misses refill whole lines one word at a time, and an
// instruction straddling two lines refills the second line on a later pass.
// Ports:
//   clk, rst_in         clock, async active-high reset
//   rdy_in              global enable, all state holds when low
//   fetch_en, fetch_pc  fetch request (bit 0 of the PC ignored)
//   flush               redirect, suppresses the lookup in IDLE
//   inst_rdy, inst_out  one-cycle response pulse and instruction window
//   mem_req, mem_addr   word read request to the memory controller
//   mem_rdy, mem_data   returned word, one pulse per word
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int WORD_BITS  = ICACHE_WORD_BITS
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  flush,
    output logic                  inst_rdy,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rdy,
    input  logic [31:0]           mem_data
);

    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - WORD_BITS - 2;
    localparam int WORDS     = 1 << WORD_BITS;
    localparam int LINE_BITS = TAG_BITS + INDEX_BITS;
    localparam int HW_W      = ADDR_WIDTH - 1;

    // Halfword address: the PC with its ignored bit 0 dropped.
    logic [HW_W-1:0]       pc_hw;
    logic [WORD_BITS-1:0]  word_a;
    logic [LINE_BITS-1:0]  line_a;
    logic [LINE_BITS-1:0]  line_b;
    logic [INDEX_BITS-1:0] idx_a;
    logic [INDEX_BITS-1:0] idx_b;
    logic [TAG_BITS-1:0]   tag_a;
    logic [TAG_BITS-1:0]   tag_b;

    assign pc_hw  = HW_W'(fetch_pc >> 1);
    assign word_a = pc_hw[WORD_BITS:1];
    assign line_a = pc_hw[HW_W-1:WORD_BITS+1];
    assign line_b = line_a + LINE_BITS'(1);
    assign idx_a  = line_a[INDEX_BITS-1:0];
    assign tag_a  = line_a[LINE_BITS-1:INDEX_BITS];
    assign idx_b  = line_b[INDEX_BITS-1:0];
    assign tag_b  = line_b[LINE_BITS-1:INDEX_BITS];

    logic                  valid_a;
    logic                  valid_b;
    logic [TAG_BITS-1:0]   rd_tag_a;
    logic [TAG_BITS-1:0]   rd_tag_b;
    logic [32*WORDS-1:0]   line_data_a;
    logic [15:0]           hw0_b;

    // Registered state
    icache_state_e         state_q,    state_d;
    logic                  inst_rdy_q, inst_rdy_d;
    logic [INST_WIDTH-1:0] inst_out_q, inst_out_d;
    logic                  mem_req_q,  mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_BITS-1:0]  word_cnt_q, word_cnt_d;
    logic [INDEX_BITS-1:0] fill_idx_q, fill_idx_d;
    logic [TAG_BITS-1:0]   fill_tag_q, fill_tag_d;

    logic                  wr_en;
    logic                  commit_en;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst_in     (rst_in),
        .wr_en      (wr_en && rdy_in),
        .wr_index   (fill_idx_q),
        .wr_word    (word_cnt_q),
        .wr_data    (mem_data),
        .commit_en  (commit_en && rdy_in),
        .commit_tag (fill_tag_q),
        .rd_index_a (idx_a),
        .rd_valid_a (valid_a),
        .rd_tag_a   (rd_tag_a),
        .rd_line_a  (line_data_a),
        .rd_index_b (idx_b),
        .rd_valid_b (valid_b),
        .rd_tag_b   (rd_tag_b),
        .rd_hw0_b   (hw0_b)
    );

    // Hit detection and halfword assembly
    logic [31:0]           cur_word;
    logic [15:0]           nxt_hw;
    logic [15:0]           lo;
    logic [15:0]           hi;
    logic                  compressed;
    logic                  need_b;
    logic                  hit_a;
    logic                  hit_b;
    logic                  hit;
    logic                  lookup;
    logic [INST_WIDTH-1:0] inst_win;

    always_comb begin
        cur_word = '0;
        nxt_hw   = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (word_a == WORD_BITS'(w)) begin
                cur_word = line_data_a[32*w +: 32];
            end
            if (WORD_BITS'(word_a + WORD_BITS'(1)) == WORD_BITS'(w)) begin
                nxt_hw = line_data_a[32*w +: 16];
            end
        end

        lo = pc_hw[0] ? cur_word[31:16] : cur_word[15:0];
        if (!pc_hw[0]) begin
            hi = cur_word[31:16];
        end else if (&word_a) begin
            hi = hw0_b;          // upper half lives in the next line
        end else begin
            hi = nxt_hw;
        end

        compressed = is_compressed(lo);
        need_b     = !compressed && pc_hw[0] && (&word_a);
        hit_a      = valid_a && (rd_tag_a == tag_a);
        hit_b      = valid_b && (rd_tag_b == tag_b);
        hit        = hit_a && (!need_b || hit_b);
        inst_win   = compressed ? {16'b0, lo} : {hi, lo};
        lookup     = (state_q == S_IDLE) && fetch_en && !flush && !inst_rdy_q;
    end

    // Next-state logic for the controller and its registered outputs
    always_comb begin
        state_d    = state_q;
        inst_rdy_d = 1'b0;
        inst_out_d = inst_out_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        word_cnt_d = word_cnt_q;
        fill_idx_d = fill_idx_q;
        fill_tag_d = fill_tag_q;
        wr_en      = 1'b0;
        commit_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (lookup) begin
                    if (hit) begin
                        inst_rdy_d = 1'b1;
                        inst_out_d = inst_win;
                    end else begin
                        // Line A is filled first; line B only once A hits.
                        fill_idx_d = hit_a ? idx_b : idx_a;
                        fill_tag_d = hit_a ? tag_b : tag_a;
                        word_cnt_d = '0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {fill_tag_d, fill_idx_d, {WORD_BITS{1'b0}}, 2'b00};
                        state_d    = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                // flush is deliberately ignored so the line always completes.
                if (mem_rdy) begin
                    wr_en = 1'b1;
                    if (word_cnt_q == WORD_BITS'(WORDS - 1)) begin
                        commit_en  = 1'b1;
                        mem_req_d  = 1'b0;
                        word_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + WORD_BITS'(1);
                        mem_addr_d = {fill_tag_q, fill_idx_q, word_cnt_d, 2'b00};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            inst_rdy_q <= 1'b0;
            inst_out_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            word_cnt_q <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            inst_rdy_q <= inst_rdy_d;
            inst_out_q <= inst_out_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            word_cnt_q <= word_cnt_d;
            fill_idx_q <= fill_idx_d;
            fill_tag_q <= fill_tag_d;
        end
    end

    assign inst_rdy = inst_rdy_q;
    assign inst_out = inst_out_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule
